// File: rtl/logic_sweep_ctrl.sv
// Purpose: self-test sequencer; walks a 2-input logic unit through all 32 {select,a,b}
//          vectors, captures its result into a truth table, counts ones, compares to GOLDEN.
// Latency: 64 busy cycles (DRIVE+SAMPLE per vector) plus one DONE cycle; pass valid after DONE.
// Backpressure: hold=1 freezes progress (operands stable, no capture), one cycle per held cycle.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 sweep request, level-sampled only in IDLE
//   hold                  pause while high during a sweep
//   in_s                  logic unit result (combinational from out_a/out_b/out_select)
//   out_a/out_b/out_select operands to the logic unit; idx = {select, a, b}
//   out_busy / out_done   busy in DRIVE/SAMPLE; one-cycle completion pulse
//   out_table/out_ones/out_pass  captured table, its ones count, match against GOLDEN
module logic_sweep_ctrl #(
    parameter logic [31:0] GOLDEN = 32'h96781E53
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hold,
    input  logic        in_s,
    output logic        out_a,
    output logic        out_b,
    output logic [2:0]  out_select,
    output logic        out_busy,
    output logic        out_done,
    output logic [31:0] out_table,
    output logic [5:0]  out_ones,
    output logic        out_pass
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] table_q, table_d;
    logic [5:0]  ones_q, ones_d;
    logic        pass_q, pass_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 5'd0;
            table_q <= 32'd0;
            ones_q  <= 6'd0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            table_q <= table_d;
            ones_q  <= ones_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // busy/done are computed from the next state so they line up with state_q
    // while still coming straight out of flops.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        table_d = table_q;
        ones_d  = ones_q;
        pass_d  = pass_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    idx_d   = 5'd0;
                    table_d = 32'd0;
                    ones_d  = 6'd0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_DRIVE: begin
                busy_d = 1'b1;
                if (!hold) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                busy_d = 1'b1;
                if (!hold) begin
                    table_d[idx_q] = in_s;
                    ones_d         = ones_q + {5'd0, in_s};
                    if (idx_q == 5'd31) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DONE: begin
                // table_q is complete here; the verdict lands as DONE exits.
                pass_d  = (table_q == GOLDEN);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operands come straight from the index flop, so they keep the last vector in IDLE/DONE.
    assign out_select = idx_q[4:2];
    assign out_a      = idx_q[1];
    assign out_b      = idx_q[0];
    assign out_busy   = busy_q;
    assign out_done   = done_q;
    assign out_table  = table_q;
    assign out_ones   = ones_q;
    assign out_pass   = pass_q;

endmodule
